// File: rtl/act_lanes.sv
// act_lanes: multi-lane fixed-point activation pipeline.
// Two-stage valid/ready pipeline. Stage 1 captures a row of lanes together
// with the configuration in force at accept time. Stage 2 registers the
// per-lane activation result (PASS / RELU / LEAKY / CLAMP).
// Optional feature macro: ACT_ROUND_EN. When defined, the leaky product is
// rounded half up before the shift. When undefined, the shift truncates
// toward minus infinity.
module act_lanes #(
    parameter int LANES = 4,
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [1:0]               cfg_mode,
    input  logic [WIDTH-1:0]         cfg_leak,
    input  logic [WIDTH-1:0]         cfg_ceil,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*WIDTH-1:0]   in_data,
    input  logic [LANES-1:0]         in_mask,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   out_data,
    output logic [LANES-1:0]         out_sat
);

    localparam logic [1:0] MODE_PASS  = 2'd0;
    localparam logic [1:0] MODE_RELU  = 2'd1;
    localparam logic [1:0] MODE_LEAKY = 2'd2;
    localparam logic [1:0] MODE_CLAMP = 2'd3;

    localparam logic [WIDTH-1:0] CEIL_RESET = {1'b0, {(WIDTH-1){1'b1}}};

    // Saturation bounds, sign-extended to the product width.
    localparam logic signed [2*WIDTH-1:0] SAT_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] SAT_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

`ifdef ACT_ROUND_EN
    localparam logic signed [2*WIDTH-1:0] ROUND_BIAS = {{(2*WIDTH-1){1'b0}}, 1'b1} << (FRAC-1);
`endif

    logic [1:0]             mode_q;
    logic [WIDTH-1:0]       leak_q;
    logic [WIDTH-1:0]       ceil_q;

    logic                   s1_valid;
    logic [LANES*WIDTH-1:0] s1_data;
    logic [LANES-1:0]       s1_mask;
    logic [1:0]             s1_mode;
    logic [WIDTH-1:0]       s1_leak;
    logic [WIDTH-1:0]       s1_ceil;

    logic                   s2_ready;
    logic                   s1_ready;
    logic [LANES*WIDTH-1:0] lane_y;
    logic [LANES-1:0]       lane_sat;

    // Per-lane activation. Returns {sat, y}.
    function automatic logic [WIDTH:0] act_lane(
        input logic [1:0]              mode,
        input logic signed [WIDTH-1:0] x,
        input logic signed [WIDTH-1:0] leak,
        input logic signed [WIDTH-1:0] ceil,
        input logic                    en
    );
        logic signed [2*WIDTH-1:0] xe;
        logic signed [2*WIDTH-1:0] le;
        logic signed [2*WIDTH-1:0] prod;
        logic signed [2*WIDTH-1:0] shifted;
        logic signed [WIDTH-1:0]   leaky;
        logic signed [WIDTH-1:0]   y;
        logic                      sat;
        xe      = {{WIDTH{x[WIDTH-1]}}, x};
        le      = {{WIDTH{leak[WIDTH-1]}}, leak};
        prod    = xe * le;
`ifdef ACT_ROUND_EN
        prod    = prod + ROUND_BIAS;
`endif
        shifted = prod >>> FRAC;
        sat     = 1'b0;
        if (shifted > SAT_MAX) begin
            leaky = SAT_MAX[WIDTH-1:0];
            sat   = 1'b1;
        end else if (shifted < SAT_MIN) begin
            leaky = SAT_MIN[WIDTH-1:0];
            sat   = 1'b1;
        end else begin
            leaky = shifted[WIDTH-1:0];
        end
        case (mode)
            MODE_PASS: begin
                y   = x;
                sat = 1'b0;
            end
            MODE_RELU: begin
                y   = x[WIDTH-1] ? '0 : x;
                sat = 1'b0;
            end
            default: begin
                if (!x[WIDTH-1]) begin
                    y   = x;
                    sat = 1'b0;
                end else begin
                    y = leaky;
                end
                if (mode == MODE_CLAMP && y > ceil) begin
                    y   = ceil;
                    sat = 1'b1;
                end
            end
        endcase
        if (!en) begin
            y   = '0;
            sat = 1'b0;
        end
        return {sat, y};
    endfunction

    // Handshake: each stage moves when the stage after it is empty or moving.
    always_comb begin
        s2_ready = !out_valid || out_ready;
        s1_ready = !s1_valid || s2_ready;
        in_ready = rst && s1_ready;
    end

    // Configuration registers, written independently of the beat flow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= MODE_LEAKY;
            leak_q <= '0;
            ceil_q <= CEIL_RESET;
        end else if (cfg_we) begin
            mode_q <= cfg_mode;
            leak_q <= cfg_leak;
            ceil_q <= cfg_ceil;
        end
    end

    // Stage 1: capture the beat and snapshot the config it will use.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mask  <= '0;
            s1_mode  <= MODE_LEAKY;
            s1_leak  <= '0;
            s1_ceil  <= CEIL_RESET;
        end else if (s1_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_mask <= in_mask;
                s1_mode <= mode_q;
                s1_leak <= leak_q;
                s1_ceil <= ceil_q;
            end
        end
    end

    // Evaluate every lane of the stage-1 beat.
    always_comb begin
        lane_y   = '0;
        lane_sat = '0;
        for (int i = 0; i < LANES; i++) begin
            {lane_sat[i], lane_y[i*WIDTH +: WIDTH]} =
                act_lane(s1_mode, s1_data[i*WIDTH +: WIDTH], s1_leak, s1_ceil, s1_mask[i]);
        end
    end

    // Stage 2: output register, held while downstream stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= lane_y;
                out_sat  <= lane_sat;
            end
        end
    end

endmodule

// File: doc/act_lanes.md
# act_lanes

Multi-lane, parametrised fixed-point activation pipeline. It generalises the single-lane leaky-ReLU cell to LANES parallel lanes, configurable WIDTH/FRAC, four activation modes, an upper clamp, saturation flags and a stallable valid/ready pipeline. It sits between the systolic array accumulator outputs and the unified buffer write port. It applies one activation per beat to a full row of lanes.

## Interface
Parameters:
- LANES, 4, number of parallel lanes
- WIDTH, 16, signed fixed-point word width
- FRAC, 8, fractional bits; Q(WIDTH-FRAC).FRAC, 1 ≤ FRAC < WIDTH

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cfg_we  in  1  load config registers this cycle
- cfg_mode  in  2  0 PASS, 1 RELU, 2 LEAKY, 3 CLAMP
- cfg_leak  in  WIDTH  signed leak factor, Q format
- cfg_ceil  in  WIDTH  signed upper clamp, used in mode 3
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  LANES*WIDTH  lane i at [i*WIDTH +: WIDTH]
- in_mask  in  LANES  1 = lane active; inactive lanes output 0
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- out_data  out  LANES*WIDTH  results, same packing
- out_sat  out  LANES  per-lane saturation/clamp occurred

## Operation
- Config registers are written on cfg_we. Reset values:
  - mode = 2
  - leak = 0
  - ceil = the most positive WIDTH value
- A beat is accepted when in_valid && in_ready. Stage 1 captures in_data, in_mask and the current config values.
  - If cfg_we and an accept happen in the same cycle, the beat takes the old config.
  - A config write never alters beats already in flight.
- Stage 2 computes each lane and registers the results into out_data/out_sat.
- Per lane, x = input and y = result:
  - PASS: y = x
  - RELU: y = (x ≥ 0) ? x : 0
  - LEAKY: y = (x ≥ 0) ? x : S(x·leak)
  - CLAMP: y = LEAKY result; if y > ceil then y = ceil
- S() rules:
  - Form the full 2·WIDTH signed product.
  - Arithmetic right shift by FRAC (floor), or round per Configuration.
  - Saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- out_sat[i] = 1 when S() saturated, or when the CLAMP ceiling was applied.
- Masked-off lanes: y = 0 and out_sat = 0, regardless of mode.
- x = 0 counts as non-negative and passes through as 0.

## Timing
- Latency: 2 cycles from accept to out_valid, with no stall.
- Throughput: 1 beat per cycle.
- Stall rules:
  - Each stage advances when its successor is empty or is advancing.
  - in_ready = !s1_valid || s1_advance, combinational from out_ready.
- While out_valid && !out_ready, out_data/out_sat/out_valid hold stable and no beat is lost or duplicated.
- Ordering is strictly FIFO. Capacity is 2 beats.
- Reset, while rst is low:
  - out_valid = 0, out_data = 0, out_sat = 0, in_ready = 0
  - config registers return to their reset values
- Reset mid-operation discards all in-flight beats. in_ready goes to 1 the first cycle after release.

## Configuration
- Macro ACT_ROUND_EN:
  - Defined: S() adds 2^(FRAC−1) to the product before the shift (round half up), then saturates.
  - Undefined: pure arithmetic-shift truncation toward −∞.
- All other behaviour is identical in both builds.

## Test plan
- Leaky, LANES=4, FRAC=8, mode 2, leak 0x0080 (0.5). Lanes {0xFE00, 0x0300, 0x0000, 0xFF00} → out {0xFF00, 0x0300, 0x0000, 0xFF80}, out_valid exactly 2 cycles after accept, out_sat = 0.
- Rounding: mode 2, leak 0x0080, x = 0xFFFF.
  - Without ACT_ROUND_EN → 0xFFFF.
  - With ACT_ROUND_EN → 0x0000.
- Saturation and mask: x = 0x8000, leak 0x8000 → 0x7FFF with out_sat = 1. Same beat with that lane's mask = 0 → 0x0000, out_sat = 0.
- Modes on one vector {0xFE00, 0x0500}:
  - PASS → {0xFE00, 0x0500}
  - RELU → {0x0000, 0x0500}
  - CLAMP with ceil 0x0100, leak 0x0080 → {0xFF00, 0x0100}, out_sat = {0, 1}
- Backpressure: stream 8 back-to-back beats with out_ready toggling pseudo-randomly. Require:
  - all 8 beats appear in order, none dropped or duplicated
  - outputs stable while stalled
  - in_ready low exactly when both stages are full and out_ready = 0
- Reset mid-stream: assert rst low with 2 beats in flight → out_valid = 0 immediately (asynchronously), config back to reset values, no stale beat emitted after release.
